// File: rtl/gray_rx_if.sv
// gray_rx_if: Gray word in, decoded value and step events out.
// master drives gray_in/clear; slave is the decoder.
interface gray_rx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             clear;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_up;
  logic             step_dn;
  logic             err;

  modport master (
    output gray_in, clear,
    input  bin_out, bin_valid,
    input  step_up, step_dn, err
  );

  modport slave (
    input  gray_in, clear,
    output bin_out, bin_valid,
    output step_up, step_dn, err
  );
endinterface

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: resync, decode and classify Gray word steps.
// Define GRAY_RX_CHECK_EN to build the illegal-jump checker.
module gray_rx_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst_n,
  gray_rx_if.slave bus
);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FILL_DONE = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] FILL_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    INIT,
    TRACK,
    ERROR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] bin_q;
  logic [CW-1:0]    fill_cnt;
  logic             valid_q;
  logic             up_q;
  logic             dn_q;
  logic             moved;
  logic             up_hit;
  logic             dn_hit;
`ifdef GRAY_RX_CHECK_EN
  logic             err_q;
`endif

  function automatic logic [WIDTH-1:0] decode(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign g_s     = sync_q[SYNC_STAGES-1];
  assign cur_bin = decode(g_s);
  assign moved   = (g_s != prev_gray);
  assign up_hit  = (cur_bin == bin_q + ONE);
  assign dn_hit  = (cur_bin == bin_q - ONE);

  // clear leaves the synchroniser running so refill starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      fill_cnt  <= '0;
      prev_gray <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
`ifdef GRAY_RX_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
      if (bus.clear) begin
        state    <= INIT;
        fill_cnt <= '0;
        valid_q  <= 1'b0;
`ifdef GRAY_RX_CHECK_EN
        err_q    <= 1'b0;
`endif
      end else begin
        case (state)
          INIT: begin
            if (fill_cnt == FILL_DONE) begin
              prev_gray <= g_s;
              bin_q     <= cur_bin;
              valid_q   <= 1'b1;
              state     <= TRACK;
            end else begin
              fill_cnt <= fill_cnt + FILL_ONE;
            end
          end
          TRACK: begin
            if (moved) begin
`ifdef GRAY_RX_CHECK_EN
              if (up_hit || dn_hit) begin
                prev_gray <= g_s;
                bin_q     <= cur_bin;
                up_q      <= up_hit;
                dn_q      <= dn_hit && !up_hit;
              end else begin
                state   <= ERROR;
                valid_q <= 1'b0;
                err_q   <= 1'b1;
              end
`else
              prev_gray <= g_s;
              bin_q     <= cur_bin;
              up_q      <= up_hit;
              dn_q      <= dn_hit && !up_hit;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.step_up   = up_q;
  assign bus.step_dn   = dn_q;
`ifdef GRAY_RX_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: directed steps with a step-pulse scoreboard.
// Checker-specific scenarios follow GRAY_RX_CHECK_EN.
module tb_gray_rx_decoder;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         compared = 0;
  int         mismatched = 0;
  int         up_seen = 0;
  int         up_base;
  logic [4:0] exp_q[$];
  logic [3:0] cur;

  gray_rx_if #(.WIDTH(W)) bus ();

  gray_rx_decoder #(
    .WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] v);
    tick;
    chk("fill1_valid", bus.bin_valid, 0);
    tick;
    chk("fill2_valid", bus.bin_valid, 0);
    tick;
    chk("settle_valid", bus.bin_valid, 1);
    chk("settle_bin", bus.bin_out, v);
    chk("settle_err", bus.err, 0);
  endtask

  task automatic step_to(input logic [3:0] v);
    logic       up;
    logic [3:0] nxt;
    nxt = cur + 4'd1;
    up = (v == nxt);
    exp_q.push_back({up, v});
    bus.gray_in = gray(v);
    tick;
    chk("hold_bin", bus.bin_out, cur);
    tick;
    chk("pre_pulse", {bus.step_up, bus.step_dn}, 0);
    tick;
    chk("step_bin", bus.bin_out, v);
    chk("pulse", {bus.step_up, bus.step_dn},
        up ? 2'b10 : 2'b01);
    tick;
    chk("post_pulse", {bus.step_up, bus.step_dn}, 0);
    cur = v;
  endtask

  always @(negedge clk) begin : mon
    logic [4:0] e;
    if (rst_n && (bus.step_up || bus.step_dn)) begin
      if (bus.step_up) up_seen++;
      chk("excl", {bus.step_up, bus.step_dn} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        chk("spurious", {bus.step_up, bus.step_dn}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_step", {bus.step_up, bus.bin_out}, e);
      end
    end
  end

  initial begin
    bus.gray_in = 4'b0110;
    bus.clear = 1'b0;
    #12;
    chk("rst_bin", bus.bin_out, 0);
    chk("rst_valid", bus.bin_valid, 0);
    chk("rst_steps", {bus.step_up, bus.step_dn}, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    settle(4'd4);
    cur = 4'd4;

    for (int v = 3; v >= 0; v--) step_to(4'(v));
    up_base = up_seen;
    for (int v = 1; v <= 16; v++) step_to(4'(v));
    chk("up_count", up_seen - up_base, 16);
    chk("wrap_bin", bus.bin_out, 0);

    for (int v = 1; v <= 5; v++) step_to(4'(v));
    exp_q.push_back({1'b0, 4'd4});
    exp_q.push_back({1'b0, 4'd3});
    bus.gray_in = 4'b0110;
    tick;
    bus.gray_in = 4'b0010;
    tick;
    chk("b2b_pre", bus.step_dn, 0);
    tick;
    chk("b2b_dn1", bus.step_dn, 1);
    chk("b2b_bin1", bus.bin_out, 4);
    tick;
    chk("b2b_dn2", bus.step_dn, 1);
    chk("b2b_bin2", bus.bin_out, 3);
    tick;
    chk("b2b_end", bus.step_dn, 0);
    cur = 4'd3;
    for (int v = 2; v >= 0; v--) step_to(4'(v));

    bus.gray_in = 4'b0011;
    tick;
    tick;
    chk("jump_pre_err", bus.err, 0);
    tick;
`ifdef GRAY_RX_CHECK_EN
    chk("jump_err", bus.err, 1);
    chk("jump_valid", bus.bin_valid, 0);
    chk("jump_bin", bus.bin_out, 0);
    bus.gray_in = 4'b0001;
    repeat (4) tick;
    chk("ign_err", bus.err, 1);
    chk("ign_bin", bus.bin_out, 0);
    chk("ign_valid", bus.bin_valid, 0);
    bus.clear = 1'b1;
    tick;
    bus.clear = 1'b0;
    chk("clr_err", bus.err, 0);
    chk("clr_valid", bus.bin_valid, 0);
    settle(4'd1);
    bus.gray_in = 4'b0101;
    repeat (3) tick;
    chk("jump2_err", bus.err, 1);
    chk("jump2_valid", bus.bin_valid, 0);
    chk("jump2_bin", bus.bin_out, 1);
    bus.clear = 1'b1;
    tick;
    bus.clear = 1'b0;
    chk("clr2_err", bus.err, 0);
    settle(4'd6);
`else
    chk("jump_bin", bus.bin_out, 2);
    chk("jump_err", bus.err, 0);
    chk("jump_valid", bus.bin_valid, 1);
    chk("jump_steps", {bus.step_up, bus.step_dn}, 0);
    cur = 4'd2;
    step_to(4'd1);
    bus.gray_in = 4'b0101;
    repeat (3) tick;
    chk("jump2_bin", bus.bin_out, 6);
    chk("jump2_err", bus.err, 0);
    chk("jump2_steps", {bus.step_up, bus.step_dn}, 0);
`endif
    cur = 4'd6;

    bus.gray_in = 4'b0000;
    tick;
    tick;
    bus.clear = 1'b1;
    tick;
    bus.clear = 1'b0;
    chk("clrwin_err", bus.err, 0);
    chk("clrwin_valid", bus.bin_valid, 0);
    chk("clrwin_bin", bus.bin_out, 6);
    settle(4'd0);
    cur = 4'd0;

    step_to(4'd1);
    tick;
    #3;
    rst_n = 1'b0;
    bus.gray_in = 4'b0110;
    #1;
    chk("arst_bin", bus.bin_out, 0);
    chk("arst_valid", bus.bin_valid, 0);
    chk("arst_steps", {bus.step_up, bus.step_dn}, 0);
    chk("arst_err", bus.err, 0);
    #2;
    rst_n = 1'b1;
    settle(4'd4);

    tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/gray_rx_decoder.md
# gray_rx_decoder

Downstream consumer of the 4-bit binary-to-Gray encoder stage. Resynchronises the registered Gray word into the local clock domain, decodes it to binary, and classifies every change as a +1 step, a -1 step or an illegal jump. The block publishes the tracked binary value, single-cycle step pulses and a sticky error flag to the position/occupancy logic that follows.

## Interface
- `WIDTH`, default 4: Gray/binary word width.
- `SYNC_STAGES`, default 2: synchroniser flop depth, minimum 2.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gray_in` in `WIDTH`: Gray word from the encoder stage, possibly from another clock domain.
- `clear` in 1: synchronous restart; re-enters INIT and clears `err`.
- `bin_out` out `WIDTH`: registered decoded binary value.
- `bin_valid` out 1: high while in TRACK.
- `step_up` out 1: one-cycle pulse when the value advances by +1 (mod 2^`WIDTH`).
- `step_dn` out 1: one-cycle pulse when the value retreats by -1 (mod 2^`WIDTH`).
- `err` out 1: sticky illegal-transition flag.

## Operation
- **Synchroniser.** A chain of `SYNC_STAGES` flops on `gray_in`. `g_s` is the last stage.
- **Decode.** Purely combinational. `b[W-1] = g[W-1]`; `b[i] = b[i+1] ^ g[i]`. `cur_bin = decode(g_s)`.
- **Internal registers.** `prev_gray` holds the last accepted Gray word. `fill_cnt` counts synchroniser fill.
- **FSM states:** INIT, TRACK, ERROR.
- **INIT**
  - `fill_cnt` increments each cycle.
  - On the edge where `fill_cnt == SYNC_STAGES`, load `prev_gray <= g_s` and `bin_out <= cur_bin`, then go to TRACK.
  - No step pulses are generated.
- **TRACK**, evaluated every cycle:
  - `g_s == prev_gray`: no change.
  - `cur_bin == bin_out + 1` (mod 2^W): accept the new value and pulse `step_up`.
  - `cur_bin == bin_out - 1` (mod 2^W): accept the new value and pulse `step_dn`.
  - Anything else is illegal. This includes a multi-bit change, and a single-bit Gray change that is not numerically adjacent (e.g. 0001→0101, which decodes 1→6).
- **Accept** means `prev_gray <= g_s` and `bin_out <= cur_bin`.
- **ERROR**
  - `bin_out` frozen, `bin_valid = 0`, `err = 1`.
  - All `gray_in` activity is ignored.
  - Only `clear` or reset exits.
- **`clear`**
  - Highest priority, in any state.
  - Next state INIT, `fill_cnt <= 0`, `err <= 0`.
  - `bin_out` holds its value, `bin_valid` drops.
  - Synchroniser flops are not cleared.
- **Wrap-around.** 2^W-1 → 0 is `step_up`; 0 → 2^W-1 is `step_dn`. All arithmetic is modulo 2^`WIDTH`.

## Timing
- **Reset.** Asynchronous on `rst_n` low. All outputs 0, synchroniser and `prev_gray` 0, `fill_cnt` 0, state INIT.
  - Reset asserted mid-TRACK or mid-ERROR forces these values immediately, without waiting for a clock edge.
- **After reset release or `clear`.** `bin_valid` rises on the (`SYNC_STAGES`+1)-th rising edge (3rd edge at default).
- **Latency in TRACK.** A `gray_in` value first captured at edge k appears on `bin_out` at edge k+`SYNC_STAGES`. Step pulses are registered and aligned with the `bin_out` update.
- **Pulse width.** Each step pulse is exactly 1 cycle. Consecutive legal changes on consecutive cycles produce back-to-back pulses.
- **Mutual exclusion.** `step_up` and `step_dn` are never high together.
- **Illegal transition.** `err` and `bin_valid` = 0 change on the same edge that would have updated `bin_out`.
- **`clear` with an illegal transition on the same cycle.** `clear` wins: `err` stays 0.

## Configuration
- **Macro:** `GRAY_RX_CHECK_EN`.
- **Defined:** the illegal-transition checker and the ERROR state are compiled in, with behaviour as above.
- **Undefined:**
  - ERROR state is absent and `err` is tied to 0.
  - Any change of `g_s` in TRACK is accepted (`bin_out <= cur_bin`, `prev_gray <= g_s`).
  - `step_up`/`step_dn` pulse only for ±1 changes; non-adjacent jumps update `bin_out` with no pulse.

## Test plan
- **Settle after reset:** reset, hold `gray_in` = 0110 → `bin_valid` = 1 on the 3rd edge, `bin_out` = 4, no step pulses, `err` = 0.
- **Full count-up with wrap:** Gray sequence for 0..15 then 0, each value held 4 cycles → 16 `step_up` pulses, each 1 cycle wide, 2 edges after capture; `bin_out` follows, including 15→0.
- **Back-to-back down steps:** 0111 (5) → 0110 (4) → 0010 (3) on consecutive cycles → `step_dn` high 2 consecutive cycles, `bin_out` = 3.
- **Illegal jump, `GRAY_RX_CHECK_EN` defined:**
  - 0000 → 0011 (0→2) → `err` = 1, `bin_valid` = 0, `bin_out` holds 0; further `gray_in` changes are ignored.
  - Pulse `clear` → `err` = 0, `bin_valid` returns after 3 edges.
  - Repeat with 0001 → 0101 → `err` = 1.
- **Same jump, `GRAY_RX_CHECK_EN` undefined:** 0000 → 0011 → `bin_out` = 2, no step pulse, `err` = 0, `bin_valid` stays 1.
- **Asynchronous reset mid-TRACK:** assert `rst_n` = 0 between edges → `bin_out`, `bin_valid`, `step_*`, `err` = 0 immediately; after release, settles per scenario 1.
